// File: rtl/rename_table_pkg.sv
// Shared types and sizes for the register-rename stage.
// The default physical register count is the core-wide register file size.
package rename_table_pkg;

  localparam int NUM_PREG = 32;
  localparam int NUM_AREG = 16;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int CNT_W    = $clog2(NUM_PREG + 1);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [3:0]        areg_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/rename_table_if.sv
// Rename-stage bus: allocation handshake toward the front end, commit and flush from retirement.
// alloc handshake: an allocation is taken on a clock edge when alloc_valid && alloc_ready && !flush;
// alloc_valid may be asserted regardless of alloc_ready, and a refused request leaves no trace.
interface rename_table_if #(parameter int NUM_PREG = rename_table_pkg::NUM_PREG);
  import rename_table_pkg::*;

  localparam int PW = $clog2(NUM_PREG);
  localparam int CW = $clog2(NUM_PREG + 1);

  logic          alloc_valid;
  areg_t         alloc_arch;
  logic          alloc_ready;
  logic [PW-1:0] p_reg;
  logic [PW-1:0] translation [NUM_AREG];
  logic [CW-1:0] free_count;
  logic          commit_valid;
  areg_t         commit_arch;
  logic [PW-1:0] commit_p_reg;
  logic          flush;

  modport master (
    output alloc_valid, alloc_arch, commit_valid, commit_arch, commit_p_reg, flush,
    input  alloc_ready, p_reg, translation, free_count
  );

  modport slave (
    input  alloc_valid, alloc_arch, commit_valid, commit_arch, commit_p_reg, flush,
    output alloc_ready, p_reg, translation, free_count
  );

endinterface

// File: rtl/rename_table_free_list_picker.sv
// Lowest-set-bit priority encoder over the free bitmap.
// o_index is 0 when nothing is set; o_any distinguishes that from bit 0 being free.
module free_list_picker #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_index,
  output logic          o_any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_index = IW'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/rename_table.sv
// Speculative and committed architectural-to-physical maps plus the free-register bitmap.
// A flush copies the committed map (with any same-cycle commit) back and rebuilds the free set.
module rename_table
  import rename_table_pkg::*;
#(
  parameter int NUM_PREG = rename_table_pkg::NUM_PREG
) (
  input  logic                 clk,
  input  logic                 n_rst,
  rename_table_if.slave        bus
);

  localparam int PW = $clog2(NUM_PREG);
  localparam int CW = $clog2(NUM_PREG + 1);

  logic [PW-1:0]       r_spec_map   [NUM_AREG];
  logic [PW-1:0]       r_commit_map [NUM_AREG];
  logic [NUM_PREG-1:0] r_free;
  logic [CW-1:0]       r_free_count;

  logic [PW-1:0]       w_p_reg;
  logic                w_any_free;
  logic                w_alloc_fire;
  logic [PW-1:0]       w_commit_old;
  logic                w_commit_frees;
  logic [PW-1:0]       w_commit_next [NUM_AREG];
  logic [NUM_PREG-1:0] w_free_next;
  logic [CW-1:0]       w_count_next;
  logic [NUM_PREG-1:0] w_flush_free;
  logic [CW-1:0]       w_flush_count;

  free_list_picker #(.N(NUM_PREG), .IW(PW)) u_picker (
    .i_vec   (r_free),
    .o_index (w_p_reg),
    .o_any   (w_any_free)
  );

  assign w_alloc_fire   = bus.alloc_valid && w_any_free && !bus.flush;
  assign w_commit_old   = r_commit_map[bus.commit_arch];
  // Re-committing the register already on record frees nothing.
  assign w_commit_frees = bus.commit_valid && (w_commit_old != bus.commit_p_reg);

  always_comb begin
    for (int i = 0; i < NUM_AREG; i++) w_commit_next[i] = r_commit_map[i];
    if (bus.commit_valid) w_commit_next[bus.commit_arch] = bus.commit_p_reg;
  end

  // Alloc and commit never touch the same bit: the freed register was committed, hence not free.
  always_comb begin
    w_free_next = r_free;
    if (w_alloc_fire)   w_free_next[w_p_reg]      = 1'b0;
    if (w_commit_frees) w_free_next[w_commit_old] = 1'b1;
    w_count_next = r_free_count + CW'(w_commit_frees) - CW'(w_alloc_fire);
  end

  always_comb begin
    logic [CW-1:0] cnt;
    w_flush_free = '1;
    for (int i = 0; i < NUM_AREG; i++) w_flush_free[w_commit_next[i]] = 1'b0;
    cnt = '0;
    for (int j = 0; j < NUM_PREG; j++) cnt = cnt + CW'(w_flush_free[j]);
    w_flush_count = cnt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        r_spec_map[i]   <= PW'(i);
        r_commit_map[i] <= PW'(i);
      end
      for (int j = 0; j < NUM_PREG; j++) r_free[j] <= (j >= NUM_AREG);
      r_free_count <= CW'(NUM_PREG - NUM_AREG);
    end else begin
      for (int i = 0; i < NUM_AREG; i++) r_commit_map[i] <= w_commit_next[i];
      if (bus.flush) begin
        for (int i = 0; i < NUM_AREG; i++) r_spec_map[i] <= w_commit_next[i];
        r_free       <= w_flush_free;
        r_free_count <= w_flush_count;
      end else begin
        if (w_alloc_fire) r_spec_map[bus.alloc_arch] <= w_p_reg;
        r_free       <= w_free_next;
        r_free_count <= w_count_next;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_AREG; i++) bus.translation[i] = r_spec_map[i];
  end

  assign bus.p_reg       = w_p_reg;
  assign bus.alloc_ready = w_any_free;
  assign bus.free_count  = r_free_count;

endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table with 32 physical registers.
// Each task drives one scenario and checks its hand-computed results inline.
module tb_rename_table;

  localparam int NP = 32;
  localparam int PW = 5;
  localparam int CW = 6;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;

  rename_table_if #(.NUM_PREG(NP)) bus ();

  rename_table #(.NUM_PREG(NP)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid  = 1'b0;
    bus.alloc_arch   = '0;
    bus.commit_valid = 1'b0;
    bus.commit_arch  = '0;
    bus.commit_p_reg = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic alloc(input logic [3:0] arch);
    bus.alloc_valid = 1'b1;
    bus.alloc_arch  = arch;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [PW-1:0] exp;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      exp = PW'(i);
      n_checks++;
      if (bus.translation[i] !== exp) begin
        n_fail++;
        $display("FAIL reset_translation[%0d]: got %0d expected %0d", i, bus.translation[i], exp);
      end
    end
    n_checks++;
    if (bus.p_reg !== 5'd16) begin
      n_fail++; $display("FAIL reset_p_reg: got %0d expected 16", bus.p_reg);
    end
    n_checks++;
    if (bus.alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_alloc_ready: got %b expected 1", bus.alloc_ready);
    end
    n_checks++;
    if (bus.free_count !== 6'd16) begin
      n_fail++; $display("FAIL reset_free_count: got %0d expected 16", bus.free_count);
    end
    // Mid-run asynchronous reset after a couple of allocations.
    alloc(4'd3);
    alloc(4'd7);
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (bus.translation[3] !== 5'd3 || bus.translation[7] !== 5'd7) begin
      n_fail++;
      $display("FAIL midreset_translation: got t3=%0d t7=%0d expected 3 7", bus.translation[3], bus.translation[7]);
    end
    n_checks++;
    if (bus.p_reg !== 5'd16 || bus.free_count !== 6'd16 || bus.alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: got p=%0d cnt=%0d rdy=%b expected 16 16 1", bus.p_reg, bus.free_count, bus.alloc_ready);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_alloc();
    apply_reset();
    bus.alloc_valid = 1'b1;
    bus.alloc_arch  = 4'd3;
    #1;
    n_checks++;
    if (bus.translation[3] !== 5'd3) begin
      n_fail++; $display("FAIL alloc_same_cycle_map: got %0d expected 3", bus.translation[3]);
    end
    tick();
    n_checks++;
    if (bus.translation[3] !== 5'd16 || bus.p_reg !== 5'd17 || bus.free_count !== 6'd15) begin
      n_fail++;
      $display("FAIL alloc_first: got t3=%0d p=%0d cnt=%0d expected 16 17 15", bus.translation[3], bus.p_reg, bus.free_count);
    end
    tick();
    bus.alloc_valid = 1'b0;
    n_checks++;
    if (bus.translation[3] !== 5'd17 || bus.p_reg !== 5'd18 || bus.free_count !== 6'd14) begin
      n_fail++;
      $display("FAIL alloc_back_to_back: got t3=%0d p=%0d cnt=%0d expected 17 18 14", bus.translation[3], bus.p_reg, bus.free_count);
    end
  endtask

  task automatic test_exhaust();
    apply_reset();
    bus.alloc_valid = 1'b1;
    bus.alloc_arch  = 4'd1;
    repeat (16) tick();
    n_checks++;
    if (bus.alloc_ready !== 1'b0 || bus.free_count !== 6'd0 || bus.p_reg !== 5'd0) begin
      n_fail++;
      $display("FAIL exhaust_state: got rdy=%b cnt=%0d p=%0d expected 0 0 0", bus.alloc_ready, bus.free_count, bus.p_reg);
    end
    n_checks++;
    if (bus.translation[1] !== 5'd31) begin
      n_fail++; $display("FAIL exhaust_last_map: got %0d expected 31", bus.translation[1]);
    end
    bus.alloc_arch = 4'd2;
    tick();
    bus.alloc_valid = 1'b0;
    n_checks++;
    if (bus.translation[2] !== 5'd2 || bus.translation[1] !== 5'd31) begin
      n_fail++;
      $display("FAIL exhaust_ignored_map: got t2=%0d t1=%0d expected 2 31", bus.translation[2], bus.translation[1]);
    end
    n_checks++;
    if (bus.alloc_ready !== 1'b0 || bus.free_count !== 6'd0) begin
      n_fail++;
      $display("FAIL exhaust_ignored_state: got rdy=%b cnt=%0d expected 0 0", bus.alloc_ready, bus.free_count);
    end
  endtask

  task automatic test_commit();
    apply_reset();
    alloc(4'd3);
    alloc(4'd4);
    bus.commit_valid = 1'b1;
    bus.commit_arch  = 4'd3;
    bus.commit_p_reg = 5'd16;
    #1;
    n_checks++;
    if (bus.p_reg !== 5'd18) begin
      n_fail++; $display("FAIL commit_not_yet_visible: got %0d expected 18", bus.p_reg);
    end
    tick();
    n_checks++;
    if (bus.p_reg !== 5'd3 || bus.free_count !== 6'd15) begin
      n_fail++;
      $display("FAIL commit_frees: got p=%0d cnt=%0d expected 3 15", bus.p_reg, bus.free_count);
    end
    // Allocation to arch 5 takes p3 while commit of arch 4 frees p4.
    bus.commit_arch  = 4'd4;
    bus.commit_p_reg = 5'd17;
    bus.alloc_valid  = 1'b1;
    bus.alloc_arch   = 4'd5;
    tick();
    bus.alloc_valid = 1'b0;
    n_checks++;
    if (bus.translation[5] !== 5'd3 || bus.p_reg !== 5'd4 || bus.free_count !== 6'd15) begin
      n_fail++;
      $display("FAIL commit_with_alloc: got t5=%0d p=%0d cnt=%0d expected 3 4 15", bus.translation[5], bus.p_reg, bus.free_count);
    end
    bus.commit_arch  = 4'd3;
    bus.commit_p_reg = 5'd16;
    tick();
    bus.commit_valid = 1'b0;
    n_checks++;
    if (bus.p_reg !== 5'd4 || bus.free_count !== 6'd15) begin
      n_fail++;
      $display("FAIL commit_duplicate: got p=%0d cnt=%0d expected 4 15", bus.p_reg, bus.free_count);
    end
  endtask

  task automatic test_flush();
    logic [PW-1:0] exp;
    int            bad;
    apply_reset();
    alloc(4'd3);
    alloc(4'd5);
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_arch  = 4'd7;
    tick();
    idle_inputs();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      exp = PW'(i);
      if (bus.translation[i] !== exp) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_identity: got t3=%0d t5=%0d t7=%0d expected 3 5 7 (%0d wrong)", bus.translation[3], bus.translation[5], bus.translation[7], bad);
    end
    n_checks++;
    if (bus.p_reg !== 5'd16 || bus.free_count !== 6'd16 || bus.alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_free_set: got p=%0d cnt=%0d rdy=%b expected 16 16 1", bus.p_reg, bus.free_count, bus.alloc_ready);
    end
  endtask

  task automatic test_flush_commit();
    apply_reset();
    alloc(4'd3);
    bus.flush        = 1'b1;
    bus.commit_valid = 1'b1;
    bus.commit_arch  = 4'd3;
    bus.commit_p_reg = 5'd16;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.translation[3] !== 5'd16 || bus.translation[0] !== 5'd0 || bus.translation[15] !== 5'd15) begin
      n_fail++;
      $display("FAIL flush_commit_map: got t3=%0d t0=%0d t15=%0d expected 16 0 15", bus.translation[3], bus.translation[0], bus.translation[15]);
    end
    n_checks++;
    if (bus.p_reg !== 5'd3 || bus.free_count !== 6'd16) begin
      n_fail++;
      $display("FAIL flush_commit_free: got p=%0d cnt=%0d expected 3 16", bus.p_reg, bus.free_count);
    end
    // The rebuilt free set must hand out p3 and then p17 (p16 is committed).
    alloc(4'd9);
    alloc(4'd10);
    n_checks++;
    if (bus.translation[9] !== 5'd3 || bus.translation[10] !== 5'd17 || bus.p_reg !== 5'd18) begin
      n_fail++;
      $display("FAIL flush_commit_realloc: got t9=%0d t10=%0d p=%0d expected 3 17 18", bus.translation[9], bus.translation[10], bus.p_reg);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc();
    test_exhaust();
    test_commit();
    test_flush();
    test_flush_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
